// File: rtl/portal_message_assembler_pkg.sv
// Shared types and header field positions for the portal message assembler.
package portal_msg_pkg;

  localparam int PORTAL_WORD_W = 32;
  localparam int HDR_ID_MSB    = 31;
  localparam int HDR_ID_LSB    = 16;
  localparam int HDR_LEN_MSB   = 15;
  localparam int HDR_LEN_LSB   = 0;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    BODY  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic logic [15:0] hdr_id(input logic [PORTAL_WORD_W-1:0] word);
    return word[HDR_ID_MSB:HDR_ID_LSB];
  endfunction

  function automatic logic [15:0] hdr_len(input logic [PORTAL_WORD_W-1:0] word);
    return word[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/portal_message_assembler_if.sv
// Enqueue-style handshake bundle: ENA action, payload, RDY back-pressure.
interface portal_message_assembler_if
  import portal_msg_pkg::*;
#(
  parameter int W = PORTAL_WORD_W
);
  logic         enq__ENA;
  logic [W-1:0] enq_v;
  logic         enq__RDY;

  modport master (output enq__ENA, output enq_v, input enq__RDY);
  modport slave  (input enq__ENA, input enq_v, output enq__RDY);
endinterface

// File: rtl/portal_message_assembler.sv
// Gathers a header word plus payload words into one wide message for the dispatcher.
// Optional feature: ASSEMBLER_LENCHK_EN drops (and counts) messages longer than the buffer.
module portal_message_assembler
  import portal_msg_pkg::*;
#(
  parameter int MAX_WORDS = 3
) (
  input  logic                              CLK,
  input  logic                              RST,
  portal_message_assembler_if.slave         in,
  portal_message_assembler_if.master        pipe,
  output logic                              busy,
  output logic [15:0]                       drop_count
);

  localparam int          MAX_PAYLOAD   = MAX_WORDS - 1;
  localparam logic [15:0] MAX_PAYLOAD_L = 16'(MAX_PAYLOAD);

  state_e                   state_r;
  state_e                   state_next_s;
  logic [PORTAL_WORD_W-1:0] buf_r [MAX_WORDS];
  logic [15:0]              len_r;
  logic [15:0]              count_r;
  logic [15:0]              drop_count_r;
  logic                     accept_s;
  logic                     last_s;
  logic                     hdr_zero_s;
`ifdef ASSEMBLER_LENCHK_EN
  logic                     hdr_over_s;
`endif

  // Word acceptance and length qualifiers
  always_comb begin
    accept_s   = in.enq__ENA && (state_r != SEND);
    last_s     = (count_r == (len_r - 16'd1));
    hdr_zero_s = (hdr_len(in.enq_v) == 16'd0);
`ifdef ASSEMBLER_LENCHK_EN
    hdr_over_s = (hdr_len(in.enq_v) > MAX_PAYLOAD_L);
`endif
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= HDR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HDR: begin
        if (!accept_s) begin
          state_next_s = HDR;
        end else if (hdr_zero_s) begin
          state_next_s = SEND;
`ifdef ASSEMBLER_LENCHK_EN
        end else if (hdr_over_s) begin
          state_next_s = DRAIN;
`endif
        end else begin
          state_next_s = BODY;
        end
      end
      BODY: begin
        if (accept_s && last_s) state_next_s = SEND;
        else                    state_next_s = BODY;
      end
      DRAIN: begin
        if (accept_s && last_s) state_next_s = HDR;
        else                    state_next_s = DRAIN;
      end
      SEND: begin
        if (pipe.enq__RDY) state_next_s = HDR;
        else               state_next_s = SEND;
      end
      default: state_next_s = HDR;
    endcase
  end

  // Message buffer and payload counter; words past the buffer are consumed but not stored
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int w = 0; w < MAX_WORDS; w++) buf_r[w] <= {PORTAL_WORD_W{1'b0}};
      len_r   <= 16'd0;
      count_r <= 16'd0;
    end else if (accept_s && (state_r == HDR)) begin
      buf_r[0] <= {16'd0, hdr_id(in.enq_v)};
      for (int w = 1; w < MAX_WORDS; w++) buf_r[w] <= {PORTAL_WORD_W{1'b0}};
      len_r   <= hdr_len(in.enq_v);
      count_r <= 16'd0;
    end else if (accept_s && (state_r == BODY)) begin
      for (int w = 1; w < MAX_WORDS; w++) begin
        if (count_r == 16'(w - 1)) buf_r[w] <= in.enq_v;
      end
      count_r <= count_r + 16'd1;
    end else if (accept_s && (state_r == DRAIN)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

`ifdef ASSEMBLER_LENCHK_EN
  // Saturating count of dropped oversize messages, bumped on the last drained word
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_count_r <= 16'd0;
    end else if (accept_s && (state_r == DRAIN) && last_s) begin
      drop_count_r <= sat_inc16(drop_count_r);
    end else begin
      drop_count_r <= drop_count_r;
    end
  end
`else
  // Truncation mode never drops, so the counter stays at zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_count_r <= 16'd0;
    end else begin
      drop_count_r <= 16'd0;
    end
  end
`endif

  // Output decode; the enqueue is only ever raised while the dispatcher is ready
  always_comb begin
    in.enq__RDY   = (state_r != SEND);
    pipe.enq__ENA = (state_r == SEND) && pipe.enq__RDY;
    busy          = (state_r != HDR);
    drop_count    = drop_count_r;
    pipe.enq_v    = {(MAX_WORDS * PORTAL_WORD_W){1'b0}};
    for (int w = 0; w < MAX_WORDS; w++) begin
      pipe.enq_v[w*PORTAL_WORD_W +: PORTAL_WORD_W] = buf_r[w];
    end
  end

endmodule

// File: tb/tb_portal_message_assembler.sv
// Directed bench for portal_message_assembler: reset, assembly, stall, oversize, reset-abort, streaming.
module tb_portal_message_assembler;

  localparam int MW = 3;
  localparam int VW = MW * 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        busy;
  logic [15:0] drop_count;
  int          checks = 0;
  int          errors = 0;
  logic [VW-1:0] sent_q[$];

  portal_message_assembler_if #(.W(32)) in_if ();
  portal_message_assembler_if #(.W(VW)) pipe_if ();

  portal_message_assembler #(.MAX_WORDS(MW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in        (in_if),
    .pipe      (pipe_if),
    .busy      (busy),
    .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  // Record every message handed to the dispatcher
  always @(negedge CLK) begin
    if (pipe_if.enq__ENA === 1'b1) sent_q.push_back(pipe_if.enq_v);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input logic [31:0] w);
    in_if.enq__ENA = 1'b1;
    in_if.enq_v    = w;
    tick();
    in_if.enq__ENA = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    in_if.enq__ENA = 1'b0;
    in_if.enq_v = 32'h0;
    pipe_if.enq__RDY = 1'b1;
    repeat (2) tick();
    checks++; if (in_if.enq__RDY !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b exp 1", in_if.enq__RDY); end
    checks++; if (pipe_if.enq__ENA !== 1'b0) begin errors++; $display("FAIL reset_pipe_ena: got %b exp 0", pipe_if.enq__ENA); end
    checks++; if (pipe_if.enq_v !== {VW{1'b0}}) begin errors++; $display("FAIL reset_pipe_v: got %h exp 0", pipe_if.enq_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %h exp 0", drop_count); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [VW-1:0] exp_v;
    int n0;
    exp_v = {32'hBBBB_0002, 32'hAAAA_0001, 32'h0000_0001};
    n0 = sent_q.size();
    pipe_if.enq__RDY = 1'b1;
    feed(32'h0001_0002);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_body: got %b exp 1", busy); end
    checks++; if (in_if.enq__RDY !== 1'b1) begin errors++; $display("FAIL basic_rdy_body: got %b exp 1", in_if.enq__RDY); end
    feed(32'hAAAA_0001);
    feed(32'hBBBB_0002);
    checks++; if (pipe_if.enq__ENA !== 1'b1) begin errors++; $display("FAIL basic_ena: got %b exp 1", pipe_if.enq__ENA); end
    checks++; if (pipe_if.enq_v !== exp_v) begin errors++; $display("FAIL basic_v: got %h exp %h", pipe_if.enq_v, exp_v); end
    checks++; if (in_if.enq__RDY !== 1'b0) begin errors++; $display("FAIL basic_rdy_send: got %b exp 0", in_if.enq__RDY); end
    tick();
    checks++; if (pipe_if.enq__ENA !== 1'b0) begin errors++; $display("FAIL basic_ena_once: got %b exp 0", pipe_if.enq__ENA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b exp 0", busy); end
    checks++; if (sent_q.size() !== n0 + 1) begin errors++; $display("FAIL basic_count: got %0d exp %0d", sent_q.size(), n0 + 1); end
  endtask

  task automatic test_zero_len;
    logic [VW-1:0] exp_v;
    int n0;
    exp_v = {32'h0, 32'h0, 32'h0000_0005};
    n0 = sent_q.size();
    feed(32'h0005_0000);
    checks++; if (pipe_if.enq__ENA !== 1'b1) begin errors++; $display("FAIL zero_ena: got %b exp 1", pipe_if.enq__ENA); end
    checks++; if (pipe_if.enq_v !== exp_v) begin errors++; $display("FAIL zero_v: got %h exp %h", pipe_if.enq_v, exp_v); end
    tick();
    checks++; if (sent_q.size() !== n0 + 1) begin errors++; $display("FAIL zero_count: got %0d exp %0d", sent_q.size(), n0 + 1); end
  endtask

  task automatic test_stall;
    logic [VW-1:0] exp_v;
    int n0;
    exp_v = {32'hBBBB_0002, 32'hAAAA_0001, 32'h0000_0001};
    n0 = sent_q.size();
    pipe_if.enq__RDY = 1'b0;
    feed(32'h0001_0002);
    feed(32'hAAAA_0001);
    feed(32'hBBBB_0002);
    for (int c = 0; c < 10; c++) begin
      in_if.enq__ENA = 1'b1;
      in_if.enq_v = 32'h0009_0001;
      checks++; if (pipe_if.enq__ENA !== 1'b0) begin errors++; $display("FAIL stall_ena c%0d: got %b exp 0", c, pipe_if.enq__ENA); end
      checks++; if (in_if.enq__RDY !== 1'b0) begin errors++; $display("FAIL stall_rdy c%0d: got %b exp 0", c, in_if.enq__RDY); end
      checks++; if (pipe_if.enq_v !== exp_v) begin errors++; $display("FAIL stall_v c%0d: got %h exp %h", c, pipe_if.enq_v, exp_v); end
      tick();
    end
    in_if.enq__ENA = 1'b0;
    pipe_if.enq__RDY = 1'b1;
    #1;
    checks++; if (pipe_if.enq__ENA !== 1'b1) begin errors++; $display("FAIL stall_release: got %b exp 1", pipe_if.enq__ENA); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b exp 0", busy); end
    checks++; if (sent_q.size() !== n0 + 1) begin errors++; $display("FAIL stall_count: got %0d exp %0d", sent_q.size(), n0 + 1); end
  endtask

  task automatic test_oversize;
    int n0;
    n0 = sent_q.size();
    pipe_if.enq__RDY = 1'b1;
    feed(32'h0002_0004);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL over_busy: got %b exp 1", busy); end
    feed(32'h1111_1111);
    feed(32'h2222_2222);
    feed(32'h3333_3333);
    feed(32'h4444_4444);
`ifdef ASSEMBLER_LENCHK_EN
    checks++; if (pipe_if.enq__ENA !== 1'b0) begin errors++; $display("FAIL over_no_ena: got %b exp 0", pipe_if.enq__ENA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL over_idle: got %b exp 0", busy); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL over_drop: got %h exp 1", drop_count); end
    tick();
    checks++; if (sent_q.size() !== n0) begin errors++; $display("FAIL over_nosend: got %0d exp %0d", sent_q.size(), n0); end
    feed(32'h0001_0002);
    feed(32'hAAAA_0001);
    feed(32'hBBBB_0002);
    checks++; if (pipe_if.enq_v !== {32'hBBBB_0002, 32'hAAAA_0001, 32'h0000_0001}) begin errors++; $display("FAIL over_next_v: got %h", pipe_if.enq_v); end
    tick();
    checks++; if (sent_q.size() !== n0 + 1) begin errors++; $display("FAIL over_next_count: got %0d exp %0d", sent_q.size(), n0 + 1); end
`else
    checks++; if (pipe_if.enq__ENA !== 1'b1) begin errors++; $display("FAIL over_ena: got %b exp 1", pipe_if.enq__ENA); end
    checks++; if (pipe_if.enq_v !== {32'h2222_2222, 32'h1111_1111, 32'h0000_0002}) begin errors++; $display("FAIL over_trunc_v: got %h", pipe_if.enq_v); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL over_drop: got %h exp 0", drop_count); end
    tick();
    checks++; if (sent_q.size() !== n0 + 1) begin errors++; $display("FAIL over_count: got %0d exp %0d", sent_q.size(), n0 + 1); end
`endif
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = sent_q.size();
    feed(32'h0001_0002);
    feed(32'hAAAA_0001);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (pipe_if.enq_v !== {VW{1'b0}}) begin errors++; $display("FAIL rstmid_v: got %h exp 0", pipe_if.enq_v); end
    feed(32'h0001_0002);
    feed(32'hAAAA_0001);
    checks++; if (pipe_if.enq__ENA !== 1'b0) begin errors++; $display("FAIL rstmid_early: got %b exp 0", pipe_if.enq__ENA); end
    feed(32'hBBBB_0002);
    checks++; if (pipe_if.enq_v !== {32'hBBBB_0002, 32'hAAAA_0001, 32'h0000_0001}) begin errors++; $display("FAIL rstmid_v2: got %h", pipe_if.enq_v); end
    tick();
    checks++; if (sent_q.size() !== n0 + 1) begin errors++; $display("FAIL rstmid_count: got %0d exp %0d", sent_q.size(), n0 + 1); end
  endtask

  task automatic test_back_to_back;
    logic [31:0]   words [6];
    logic [VW-1:0] exp_v [3];
    logic [15:0]   rdy_pat;
    int n0;
    int idx;
    int cyc;
    words = '{32'h0003_0001, 32'hCAFE_0001, 32'h0004_0000, 32'h0006_0002, 32'h1234_5678, 32'h9ABC_DEF0};
    exp_v[0] = {32'h0, 32'hCAFE_0001, 32'h0000_0003};
    exp_v[1] = {32'h0, 32'h0, 32'h0000_0004};
    exp_v[2] = {32'h9ABC_DEF0, 32'h1234_5678, 32'h0000_0006};
    rdy_pat = 16'b1011_0010_1101_0110;
    n0 = sent_q.size();
    idx = 0;
    cyc = 0;
    while ((sent_q.size() < n0 + 3) && (cyc < 200)) begin
      pipe_if.enq__RDY = rdy_pat[cyc % 16];
      if (idx < 6) begin
        in_if.enq__ENA = 1'b1;
        in_if.enq_v = words[idx];
        if (in_if.enq__RDY === 1'b1) idx++;
      end else begin
        in_if.enq__ENA = 1'b0;
      end
      tick();
      cyc++;
    end
    in_if.enq__ENA = 1'b0;
    pipe_if.enq__RDY = 1'b1;
    checks++; if (sent_q.size() !== n0 + 3) begin errors++; $display("FAIL b2b_count: got %0d exp %0d after %0d cycles", sent_q.size(), n0 + 3, cyc); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ((n0 + k >= sent_q.size()) || (sent_q[n0 + k] !== exp_v[k])) begin
        errors++;
        $display("FAIL b2b_msg%0d: missing or wrong, exp %h", k, exp_v[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_oversize();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
